if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Registers each fetched word with its PC into the IF/ID output register, which feeds the decoder's inst input.
- Handles stall from the hazard unit and redirect (branch/jump/jr) from later stages, including discarding in-flight fetches.

Parameters:
- PC_WIDTH, 32, width of PC and instruction address.
- INST_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  hazard unit: hold the IF/ID output, do not advance.
- redirect_valid_i  in  1  taken branch/jump: fetch must restart at redirect_pc_i.
- redirect_pc_i  in  PC_WIDTH  redirect target, word aligned.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  PC_WIDTH  fetch address; stable while imem_req_o is high and not acked.
- imem_ack_i  in  1  imem_rdata_i is valid this cycle; completes the current request.
- imem_rdata_i  in  INST_WIDTH  fetched word.
- inst_o  out  INST_WIDTH  instruction to the decoder; 0 (NOP) when invalid.
- pc_o  out  PC_WIDTH  PC of inst_o.
- pc_plus4_o  out  PC_WIDTH  pc_o+4, link value for jal.
- inst_valid_o  out  1  inst_o holds a live instruction.

Behaviour:
- Reset (rst=1 at an edge): fetch_pc=RESET_PC, imem_req_o=0, inst_valid_o=0, inst_o=0, pc_o=0, pc_plus4_o=4, buffer empty, state=S_IDLE.
- States:
  - S_IDLE: drive req next cycle, go to S_REQ. Entered only from reset.
  - S_REQ: imem_req_o=1, imem_addr_o=fetch_pc. On ack with no redirect:
    - If the output is free (not (inst_valid_o && stall_i)), load inst_o/pc_o and set inst_valid_o=1. Set fetch_pc+=4 (mod 2^PC_WIDTH, wraps) and stay in S_REQ, so back-to-back requests are allowed.
    - Otherwise, place the word in the 1-entry buffer and go to S_FULL.
  - S_FULL: imem_req_o=0. When stall_i drops, the buffer moves to the output register at that edge, then go to S_REQ.
  - S_KILL: request outstanding but stale; imem_req_o stays 1 with the old address until ack. The acked data is dropped, then go to S_REQ with fetch_pc = latched redirect target.
- Latency: ack at edge N puts the word on inst_o after edge N, i.e. in cycle N+1. Memory must ack no earlier than the cycle after req rises.
- Output register: holds its value while inst_valid_o && stall_i. If no word is available and the stage is not stalled, inst_valid_o drops to 0 and inst_o becomes 0.
- Redirect (any state; overrides stall):
  - Next edge: inst_valid_o=0, inst_o=0, buffer cleared.
  - Ack in the same cycle: data discarded; go to S_REQ at redirect_pc_i.
  - S_REQ with no ack: go to S_KILL, latch the target.
  - S_KILL: re-latch the target; the newest redirect wins.
  - S_FULL: go to S_REQ at redirect_pc_i.
- Reset mid-request: state returns to S_IDLE. Any ack arriving during or after reset while in S_IDLE is ignored.

Optional Feature:
- Macro: IF_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot.
  - A redirect does not flush inst_o if it holds the sequential successor of the branch (pc_o == branch_pc+4). Otherwise, the next sequentially fetched word is still delivered as valid.
  - The target is held in pending_redirect and applied to fetch_pc after the delay-slot instruction is accepted (output loaded).
  - A second redirect while one is pending is ignored.
- Undefined: redirect flushes immediately as above, with no pending register. The block also needs branch_pc_i (PC_WIDTH, in) only when the macro is defined.

Decomposition:
- Shared defines header: InstAddrWidth, InstDataWidth, ZeroWord/NOP, RstEnable, RESET_PC, fetch state encodings S_IDLE/S_REQ/S_FULL/S_KILL (2 bits).
- One natural sub-module: if_id_reg, the output register with load/hold/flush controls, reused for pc_o/pc_plus4_o/inst_o/inst_valid_o.

Test Plan:
- Reset release, memory acks one cycle after each req with word = addr^32'hA5A5_0000 → addresses 0,4,8,… in order. The first inst_valid_o appears 1 cycle after the first ack, with pc_o=0 and pc_plus4_o=4.
- stall_i high for 3 cycles while a fetch of addr 8 acks → buffer holds it and req stays low. inst_o/pc_o stay at pc 4; after stall drops, pc_o=8 next cycle, then req to 12.
- Redirect to 0x100 while the request for 0x10 is outstanding, ack 2 cycles later → 0x10 data never reaches inst_o. The next req address is 0x100; inst_valid_o=0 in between.
- Redirect and ack in the same cycle plus stall_i=1 → flush wins: inst_valid_o=0 next cycle, next imem_addr_o=redirect_pc_i.
- fetch_pc=32'hFFFF_FFFC with ack → next imem_addr_o=0 (wrap), pc_plus4_o=0.
- IF_DELAY_SLOT_EN, branch at 0x20 redirects to 0x80 → 0x24 is delivered valid, then 0x80; 0x28 is never delivered.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared widths, constants and fetch state encodings
package if_fetch_stage_pkg;

    localparam int InstAddrWidth = 32;
    localparam int InstDataWidth = 32;

    localparam logic [InstDataWidth-1:0] ZeroWord = '0;
    localparam logic [InstDataWidth-1:0] NOP      = ZeroWord;
    localparam logic                     RstEnable = 1'b1;
    localparam logic [InstAddrWidth-1:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_FULL = 2'b10,
        S_KILL = 2'b11
    } fetchState_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction memory req/ack bus between fetch stage and memory
interface if_fetch_stage_if #(
    parameter int PC_WIDTH   = if_fetch_stage_pkg::InstAddrWidth,
    parameter int INST_WIDTH = if_fetch_stage_pkg::InstDataWidth
);
    logic                  imem_req_o;
    logic [PC_WIDTH-1:0]   imem_addr_o;
    logic                  imem_ack_i;
    logic [INST_WIDTH-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// rtl/if_fetch_stage_if_id_reg.sv - IF/ID output register with flush/load/hold controls
module if_id_reg #(
    parameter int PC_WIDTH   = if_fetch_stage_pkg::InstAddrWidth,
    parameter int INST_WIDTH = if_fetch_stage_pkg::InstDataWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  flush,
    input  logic                  stall,
    input  logic [INST_WIDTH-1:0] instIn,
    input  logic [PC_WIDTH-1:0]   pcIn,
    output logic [INST_WIDTH-1:0] instOut,
    output logic [PC_WIDTH-1:0]   pcOut,
    output logic [PC_WIDTH-1:0]   pcPlus4Out,
    output logic                  validOut
);
    import if_fetch_stage_pkg::*;

    // Flush beats load, load beats hold; an unstalled empty slot decays to a NOP.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            instOut    <= INST_WIDTH'(ZeroWord);
            pcOut      <= '0;
            pcPlus4Out <= PC_WIDTH'(4);
            validOut   <= 1'b0;
        end else if (flush) begin
            instOut  <= INST_WIDTH'(NOP);
            validOut <= 1'b0;
        end else if (load) begin
            instOut    <= instIn;
            pcOut      <= pcIn;
            pcPlus4Out <= pcIn + PC_WIDTH'(4);
            validOut   <= 1'b1;
        end else if (!(validOut && stall)) begin
            instOut  <= INST_WIDTH'(NOP);
            validOut <= 1'b0;
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS IF stage: PC, imem req/ack, skid buffer, redirect kill
// Optional branch delay slot handling when IF_DELAY_SLOT_EN is defined.
module if_fetch_stage #(
    parameter int                  PC_WIDTH   = if_fetch_stage_pkg::InstAddrWidth,
    parameter int                  INST_WIDTH = if_fetch_stage_pkg::InstDataWidth,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(if_fetch_stage_pkg::RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_valid_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
`ifdef IF_DELAY_SLOT_EN
    input  logic [PC_WIDTH-1:0]   branch_pc_i,
`endif
    if_fetch_stage_if.master      imem,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [PC_WIDTH-1:0]   pc_plus4_o,
    output logic                  inst_valid_o
);
    import if_fetch_stage_pkg::*;

    fetchState_t state, stateNext;

    logic [PC_WIDTH-1:0]   fetchPc, killPc, bufPc, pendingTarget;
    logic [INST_WIDTH-1:0] bufInst;
    logic outFree, redirectKill, flushOut, applyPending;
    logic req, loadOut, loadFromBuf, bufWr, pcAdv, pcRedir, pcKill, killLatch;

    assign outFree = !(inst_valid_o && stall_i);

`ifdef IF_DELAY_SLOT_EN
    logic                pendingValid, redirectNew, slotInOut;
    logic [PC_WIDTH-1:0] pendingPc;

    // If the delay slot already sits in IF/ID the sequential stream behind it is dead;
    // otherwise the next sequential word is the slot and the target waits for it.
    assign redirectNew   = redirect_valid_i && !pendingValid;
    assign slotInOut     = inst_valid_o && (pc_o == branch_pc_i + PC_WIDTH'(4));
    assign redirectKill  = redirectNew && slotInOut;
    assign flushOut      = 1'b0;
    assign applyPending  = loadOut && (pendingValid || (redirectNew && !slotInOut));
    assign pendingTarget = pendingValid ? pendingPc : redirect_pc_i;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pendingValid <= 1'b0;
            pendingPc    <= '0;
        end else if (applyPending) begin
            pendingValid <= 1'b0;
        end else if (redirectNew && !slotInOut) begin
            pendingValid <= 1'b1;
            pendingPc    <= redirect_pc_i;
        end
    end
`else
    assign redirectKill  = redirect_valid_i;
    assign flushOut      = redirect_valid_i;
    assign applyPending  = 1'b0;
    assign pendingTarget = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst == RstEnable) state <= S_IDLE;
        else                  state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        req         = 1'b0;
        loadOut     = 1'b0;
        loadFromBuf = 1'b0;
        bufWr       = 1'b0;
        pcAdv       = 1'b0;
        pcRedir     = 1'b0;
        pcKill      = 1'b0;
        killLatch   = 1'b0;
        case (state)
            S_IDLE: begin
                stateNext = S_REQ;
                pcRedir   = redirectKill;
            end
            S_REQ: begin
                req = 1'b1;
                if (redirectKill) begin
                    if (imem.imem_ack_i) begin
                        pcRedir = 1'b1;
                    end else begin
                        stateNext = S_KILL;
                        killLatch = 1'b1;
                    end
                end else if (imem.imem_ack_i) begin
                    pcAdv = 1'b1;
                    if (outFree) begin
                        loadOut = 1'b1;
                    end else begin
                        bufWr     = 1'b1;
                        stateNext = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (redirectKill) begin
                    stateNext = S_REQ;
                    pcRedir   = 1'b1;
                end else if (!stall_i) begin
                    loadOut     = 1'b1;
                    loadFromBuf = 1'b1;
                    stateNext   = S_REQ;
                end
            end
            S_KILL: begin
                // Address must stay put until the stale request is acked and dropped.
                req       = 1'b1;
                killLatch = redirectKill;
                if (imem.imem_ack_i) begin
                    stateNext = S_REQ;
                    pcRedir   = redirectKill;
                    pcKill    = !redirectKill;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            fetchPc <= RESET_PC;
            killPc  <= '0;
            bufPc   <= '0;
            bufInst <= '0;
        end else begin
            if (pcRedir)           fetchPc <= redirect_pc_i;
            else if (pcKill)       fetchPc <= killPc;
            else if (applyPending) fetchPc <= pendingTarget;
            else if (pcAdv)        fetchPc <= fetchPc + PC_WIDTH'(4);
            if (killLatch) killPc <= redirect_pc_i;
            if (bufWr) begin
                bufPc   <= fetchPc;
                bufInst <= imem.imem_rdata_i;
            end
        end
    end

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = fetchPc;

    if_id_reg #(
        .PC_WIDTH  (PC_WIDTH),
        .INST_WIDTH(INST_WIDTH)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (loadOut),
        .flush     (flushOut),
        .stall     (stall_i),
        .instIn    (loadFromBuf ? bufInst : imem.imem_rdata_i),
        .pcIn      (loadFromBuf ? bufPc : fetchPc),
        .instOut   (inst_o),
        .pcOut     (pc_o),
        .pcPlus4Out(pc_plus4_o),
        .validOut  (inst_valid_o)
    );
endmodule
